// File: rtl/tap_mixer.sv
// tap_mixer: sequential FIR-style tap mixer with double-buffered coefficients.
//
// A delay-line snapshot (NTAPS signed taps) is latched on sample_valid. It is
// multiply-accumulated one tap per cycle against the active coefficient bank.
// The sum is then rounded and shifted right by COEF_FRAC (= COEF_W-1) and
// presented on out_sample with a one-cycle out_valid pulse.
// Latency is sample_valid at cycle 0 to out_valid at cycle NTAPS+2.
//
// Ports:
//   clock        in   sole clock, rising edge
//   resetn       in   asynchronous active-low reset
//   sample_valid in   strobe: taps holds a new snapshot
//   taps         in   WIDTH*NTAPS, tap k at [WIDTH*k +: WIDTH], k=0 newest
//   coef_we      in   coefficient write strobe (pending bank)
//   coef_addr    in   coefficient index, >= NTAPS ignored
//   coef_data    in   signed coefficient
//   out_sample   out  signed mixed sample, held between pulses
//   out_valid    out  one-cycle pulse when out_sample updates
//   busy         out  mix in progress
//   overrun      out  sticky: a sample_valid arrived while busy
//
// Optional feature: define TAP_MIXER_SAT_EN to clamp the rounded result to the
// WIDTH signed range. The default build wraps to the low WIDTH bits.
module tap_mixer #(
    parameter int WIDTH  = 16,
    parameter int NTAPS  = 8,
    parameter int COEF_W = 8
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   sample_valid,
    input  logic [WIDTH*NTAPS-1:0] taps,
    input  logic                   coef_we,
    input  logic [2:0]             coef_addr,
    input  logic [COEF_W-1:0]      coef_data,
    output logic [WIDTH-1:0]       out_sample,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   overrun
);

    localparam int COEF_FRAC = COEF_W - 1;
    localparam int PROD_W    = WIDTH + COEF_W;
    localparam int ACC_W     = WIDTH + COEF_W + 3;
    localparam int IDX_W     = (NTAPS > 1) ? $clog2(NTAPS) : 1;

    // Unity-gain moving average: each coefficient is 1/NTAPS in Q(COEF_FRAC).
    localparam logic [COEF_W-1:0] COEF_RST = COEF_W'((1 << COEF_FRAC) / NTAPS);
    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (COEF_FRAC - 1);

    typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

    state_t state, state_d;

    logic [NTAPS-1:0][WIDTH-1:0]  snap;
    logic [NTAPS-1:0][COEF_W-1:0] coef_pend;
    logic [NTAPS-1:0][COEF_W-1:0] coef_act;
    logic signed [ACC_W-1:0]      acc;
    logic [IDX_W-1:0]             idx;
    logic signed [PROD_W-1:0]     prod;
    logic [WIDTH-1:0]             res;
    logic                         accept;
    logic                         addr_ok;

    // A 3-bit address can only reach an invalid index when NTAPS < 8.
    generate
        if (NTAPS >= 8) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_chk
            assign addr_ok = (coef_addr < 3'(NTAPS));
        end
    endgenerate

    assign busy = (state != IDLE);
    assign prod = PROD_W'($signed(snap[idx])) * PROD_W'($signed(coef_act[idx]));

    // Round half up, then arithmetic shift back to sample scale.
`ifdef TAP_MIXER_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    logic signed [ACC_W-1:0] rnd;

    always_comb begin
        rnd = (acc + RND_HALF) >>> COEF_FRAC;
        if (rnd > SAT_MAX)
            res = SAT_MAX[WIDTH-1:0];
        else if (rnd < SAT_MIN)
            res = SAT_MIN[WIDTH-1:0];
        else
            res = rnd[WIDTH-1:0];
    end
`else
    assign res = WIDTH'((acc + RND_HALF) >>> COEF_FRAC);
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (sample_valid) begin
                    accept  = 1'b1;
                    state_d = MAC;
                end
            end
            MAC:     if (idx == IDX_W'(NTAPS - 1)) state_d = ROUND;
            ROUND:   state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            snap       <= '0;
            coef_pend  <= {NTAPS{COEF_RST}};
            coef_act   <= {NTAPS{COEF_RST}};
            acc        <= '0;
            idx        <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (coef_we && addr_ok)
                coef_pend[coef_addr] <= coef_data;
            // Same-cycle write sees the old pending value copied here, so it
            // only reaches the active bank on the next accept.
            if (accept) begin
                coef_act <= coef_pend;
                snap     <= taps;
                acc      <= '0;
                idx      <= '0;
            end
            if (state == MAC) begin
                acc <= acc + ACC_W'(prod);
                idx <= idx + IDX_W'(1);
            end
            // Registered on the ROUND->OUT edge so the pulse and data appear
            // together during OUT.
            out_valid <= (state == ROUND);
            if (state == ROUND)
                out_sample <= res;
            if (sample_valid && busy)
                overrun <= 1'b1;
        end
    end

endmodule
